// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with load clamp, terminal count and wrap pulse.
// Define MOD_COUNTER_SATURATE_EN to hold at the bounds instead of wrapping.
module mod_updown_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 10,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RstVal = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             lerr_q, lerr_d;
  logic             at_max, at_zero, in_range;

  assign at_max   = (q_q == MaxVal);
  assign at_zero  = (q_q == '0);
  // MaxVal always fits in WIDTH bits, so <= avoids forming MODULUS itself
  assign in_range = (load_val <= MaxVal);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    lerr_d = 1'b0;
    if (load) begin
      q_d    = in_range ? load_val : MaxVal;
      lerr_d = ~in_range;
    end else if (en) begin
      if (up_dn) begin
        if (at_max) begin
`ifdef MOD_COUNTER_SATURATE_EN
          q_d    = q_q;
`else
          q_d    = '0;
          wrap_d = 1'b1;
`endif
        end else begin
          q_d = q_q + 1'b1;
        end
      end else begin
        if (at_zero) begin
`ifdef MOD_COUNTER_SATURATE_EN
          q_d    = q_q;
`else
          q_d    = MaxVal;
          wrap_d = 1'b1;
`endif
        end else begin
          q_d = q_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= RstVal;
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      lerr_q <= lerr_d;
    end
  end

  assign q        = q_q;
  assign wrap     = wrap_q;
  assign load_err = lerr_q;
  assign tc       = en & ~load & ((up_dn & at_max) | (~up_dn & at_zero));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomized bench for mod_updown_counter against an arithmetic model.
// Honours MOD_COUNTER_SATURATE_EN in the model as well.
module tb_mod_updown_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         up_dn = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic         tc, wrap, load_err;

  int n_cmp = 0;
  int n_bad = 0;

  int qm = 0;
  int wm = 0;
  int em = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(
    .WIDTH(W), .MODULUS(M), .RESET_VAL(0)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn),
    .load(load), .load_val(load_val),
    .q(q), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, l, e, u, input int v);
    int nxt;
    if (r) begin
      qm = 0; wm = 0; em = 0;
    end else if (l) begin
      wm = 0;
      em = (v >= M) ? 1 : 0;
      qm = (v < M) ? v : M - 1;
    end else begin
      em = 0;
      wm = 0;
      if (e) begin
        nxt = u ? qm + 1 : qm - 1;
        if (nxt < 0 || nxt >= M) begin
`ifndef MOD_COUNTER_SATURATE_EN
          wm = 1;
          qm = (nxt + M) % M;
`endif
        end else begin
          qm = nxt;
        end
      end
    end
  endtask

  task automatic step(input bit r, l, e, u, input int v);
    int tce;
    @(negedge clk);
    rst = r; load = l; en = e; up_dn = u; load_val = W'(v);
    #1;
    tce = (e && !l && (u ? (qm == M - 1) : (qm == 0))) ? 1 : 0;
    check("tc", int'(tc), tce);
    @(posedge clk);
    model(r, l, e, u, v);
    #1;
    check("q", int'(q), qm);
    check("wrap", int'(wrap), wm);
    check("load_err", int'(load_err), em);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset dominates load and enable
    step(1, 1, 1, 1, 5);
    step(1, 1, 1, 1, 5);
    check("reset_q", int'(q), 0);

    // count up 12 edges from 0
    for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 0);
`ifndef MOD_COUNTER_SATURATE_EN
    check("up_end_q", int'(q), 2);
`else
    check("sat_up_q", int'(q), 9);
`endif

    // load 1, then count down 3 edges
    step(0, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
`ifndef MOD_COUNTER_SATURATE_EN
    check("down_end_q", int'(q), 8);
`else
    check("sat_down_q", int'(q), 0);
`endif

    // load priority and clamp
    step(0, 1, 1, 1, 7);
    check("load7_q", int'(q), 7);
    step(0, 1, 1, 0, 13);
    check("clamp_q", int'(q), 9);
    check("clamp_err", int'(load_err), 1);
    step(0, 0, 0, 1, 0);
    check("err_clear", int'(load_err), 0);

    // mid-count reset at 6, then hold
    step(0, 1, 0, 1, 4);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(1, 0, 1, 1, 0);
    check("midrst_q", int'(q), 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);

    // boundary loads
    step(0, 1, 0, 1, 9);
    step(0, 1, 0, 1, 10);
    step(0, 1, 0, 1, 15);
    step(0, 1, 0, 1, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 1),
           int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
